// File: rtl/quiz_pkg.sv
// Shared types and helpers for the quiz round controller: FSM states, player IDs,
// winner codes and the remote key-bit to choice decode.
package quiz_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_ANS = 3'd1,
      JUDGE    = 3'd2,
      NEXT     = 3'd3,
      DONE     = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      PLY_NONE = 2'd0,
      PLY_1    = 2'd1,
      PLY_2    = 2'd2
   } player_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   localparam logic [1:0] WIN_TIE  = 2'b11;

   // Both players' nibbles map the same way: nibble bit3 is choice 1, bit0 is choice 4.
   localparam logic [2:0] CHOICE_NONE = 3'd0;
   localparam logic [2:0] CHOICE_B3   = 3'd1;
   localparam logic [2:0] CHOICE_B2   = 3'd2;
   localparam logic [2:0] CHOICE_B1   = 3'd3;
   localparam logic [2:0] CHOICE_B0   = 3'd4;

   function automatic logic exactly_one_low(input logic [3:0] keys);
      logic result;
      case (keys)
         4'b0111, 4'b1011, 4'b1101, 4'b1110: result = 1'b1;
         default:                            result = 1'b0;
      endcase
      return result;
   endfunction

   function automatic logic [2:0] key_to_choice(input logic [3:0] keys);
      logic [2:0] result;
      case (keys)
         4'b0111: result = CHOICE_B3;
         4'b1011: result = CHOICE_B2;
         4'b1101: result = CHOICE_B1;
         4'b1110: result = CHOICE_B0;
         default: result = CHOICE_NONE;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/remote_group_debounce.sv
// Debounces one player's 4-key active-low group and emits a single-cycle
// valid pulse with the decoded choice once per key-down.
module remote_group_debounce
   import quiz_pkg::*;
#(
   parameter int DEBOUNCE = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] keys,
   output logic       valid,
   output logic [2:0] choice
);

   localparam int CNT_W = $clog2(DEBOUNCE + 1) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);

   logic [3:0]       prev_r;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_s;
   logic             armed_r;
   logic             fire_s;
   logic             rearm_s;
   logic             valid_r;
   logic [2:0]       choice_r;

   // Stability counter: number of consecutive cycles the group has read the same pattern.
   always_comb begin
      cnt_s = CNT_W'(1);
      if (keys == prev_r) begin
         if (cnt_r >= CNT_MAX) begin
            cnt_s = CNT_MAX;
         end else begin
            cnt_s = cnt_r + 1'b1;
         end
      end else begin
         cnt_s = CNT_W'(1);
      end
      fire_s  = armed_r && (cnt_s == CNT_MAX) && exactly_one_low(keys);
      rearm_s = (keys == 4'hF) && (cnt_s == CNT_MAX);
   end

   // Armed only after a stable all-high release, so a held key never repeats.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_r   <= 4'hF;
         cnt_r    <= '0;
         armed_r  <= 1'b0;
         valid_r  <= 1'b0;
         choice_r <= CHOICE_NONE;
      end else begin
         prev_r  <= keys;
         cnt_r   <= cnt_s;
         valid_r <= fire_s;
         if (fire_s) begin
            armed_r  <= 1'b0;
            choice_r <= key_to_choice(keys);
         end else if (rearm_s) begin
            armed_r  <= 1'b1;
            choice_r <= CHOICE_NONE;
         end else begin
            choice_r <= CHOICE_NONE;
         end
      end
   end

   assign valid  = valid_r;
   assign choice = choice_r;

endmodule

// File: rtl/quiz_round_ctrl.sv
// Quiz round sequencer: synchronises and debounces both remotes, arbitrates presses,
// judges answers against the problem ROM, keeps scores and declares the winner.
module quiz_round_ctrl
   import quiz_pkg::*;
#(
   parameter int NUM_PROBLEMS = 10,
   parameter int ANS_TIMEOUT  = 1000,
   parameter int DEBOUNCE     = 4,
   parameter int SCORE_W      = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [7:0]         rm_in_bcd,
   input  logic [3:0]         prob_ans,
   output logic [7:0]         prob_idx,
   output logic               next_prob,
   output logic [SCORE_W-1:0] score_p1,
   output logic [SCORE_W-1:0] score_p2,
   output logic               lock_p1,
   output logic               lock_p2,
   output logic               round_done,
   output logic [1:0]         winner
);

   localparam int TMR_W = (ANS_TIMEOUT > 1) ? $clog2(ANS_TIMEOUT) : 1;
   localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(ANS_TIMEOUT - 1);
   localparam logic [7:0]         LAST_IDX  = 8'(NUM_PROBLEMS - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

   logic [7:0]         sync1_r, sync2_r;
   logic               p1_valid_s, p2_valid_s;
   logic [2:0]         p1_choice_s, p2_choice_s;
   state_t             state_r, state_s;
   player_t            pointer_r, grant_s, player_r;
   logic [2:0]         grant_choice_s, choice_r;
   logic               req1_s, req2_s, toggle_s;
   logic               start_round_s, correct_s, both_locked_s;
   logic [TMR_W-1:0]   timer_r;
   logic [7:0]         idx_r;
   logic [SCORE_W-1:0] s1_r, s2_r;
   logic               lk1_r, lk2_r;
   logic               next_prob_r, round_done_r;
   logic [1:0]         winner_r, winner_s;

   // Two-flop synchroniser; idles at all-high so reset does not look like a press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r <= 8'hFF;
         sync2_r <= 8'hFF;
      end else begin
         sync1_r <= rm_in_bcd;
         sync2_r <= sync1_r;
      end
   end

   remote_group_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_p1 (
      .clk    (clk),
      .rst    (rst),
      .keys   (sync2_r[7:4]),
      .valid  (p1_valid_s),
      .choice (p1_choice_s)
   );

   remote_group_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_p2 (
      .clk    (clk),
      .rst    (rst),
      .keys   (sync2_r[3:0]),
      .valid  (p2_valid_s),
      .choice (p2_choice_s)
   );

   // Arbiter: locked players are ignored; a tie goes to the pointer's player.
   always_comb begin
      req1_s         = p1_valid_s && !lk1_r;
      req2_s         = p2_valid_s && !lk2_r;
      grant_s        = PLY_NONE;
      grant_choice_s = CHOICE_NONE;
      toggle_s       = 1'b0;
      if (req1_s && req2_s) begin
         toggle_s = 1'b1;
         grant_s  = pointer_r;
         if (pointer_r == PLY_2) begin
            grant_choice_s = p2_choice_s;
         end else begin
            grant_choice_s = p1_choice_s;
         end
      end else if (req1_s) begin
         grant_s        = PLY_1;
         grant_choice_s = p1_choice_s;
      end else if (req2_s) begin
         grant_s        = PLY_2;
         grant_choice_s = p2_choice_s;
      end else begin
         grant_s        = PLY_NONE;
         grant_choice_s = CHOICE_NONE;
      end
   end

   // Next-state logic and judging terms.
   always_comb begin
      state_s       = state_r;
      start_round_s = start && ((state_r == IDLE) || (state_r == DONE));
      correct_s     = ({1'b0, choice_r} == prob_ans);
      both_locked_s = ((player_r == PLY_1) || lk1_r) && ((player_r == PLY_2) || lk2_r);
      if (s1_r > s2_r) begin
         winner_s = WIN_P1;
      end else if (s2_r > s1_r) begin
         winner_s = WIN_P2;
      end else begin
         winner_s = WIN_TIE;
      end
      case (state_r)
         IDLE: begin
            if (start_round_s) state_s = WAIT_ANS;
            else               state_s = IDLE;
         end
         WAIT_ANS: begin
            if (grant_s != PLY_NONE)    state_s = JUDGE;
            else if (timer_r >= TMR_LAST) state_s = NEXT;
            else                        state_s = WAIT_ANS;
         end
         JUDGE: begin
            if (correct_s || both_locked_s) state_s = NEXT;
            else                            state_s = WAIT_ANS;
         end
         NEXT: begin
            if (idx_r == LAST_IDX) state_s = DONE;
            else                   state_s = WAIT_ANS;
         end
         DONE: begin
            if (start_round_s) state_s = WAIT_ANS;
            else               state_s = DONE;
         end
         default: state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= IDLE;
      else     state_r <= state_s;
   end

   // Round datapath: index, timer, scores, locks, arbitration pointer and grant capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_r     <= 8'd0;
         timer_r   <= '0;
         s1_r      <= '0;
         s2_r      <= '0;
         lk1_r     <= 1'b0;
         lk2_r     <= 1'b0;
         pointer_r <= PLY_1;
         player_r  <= PLY_NONE;
         choice_r  <= CHOICE_NONE;
      end else if (start_round_s) begin
         idx_r   <= 8'd0;
         timer_r <= '0;
         s1_r    <= '0;
         s2_r    <= '0;
         lk1_r   <= 1'b0;
         lk2_r   <= 1'b0;
      end else begin
         case (state_r)
            WAIT_ANS: begin
               if (timer_r < TMR_LAST) timer_r <= timer_r + 1'b1;
               if (grant_s != PLY_NONE) begin
                  player_r <= grant_s;
                  choice_r <= grant_choice_s;
               end
               if (toggle_s) pointer_r <= (pointer_r == PLY_1) ? PLY_2 : PLY_1;
            end
            JUDGE: begin
               if (timer_r < TMR_LAST) timer_r <= timer_r + 1'b1;
               if (correct_s) begin
                  if (player_r == PLY_1 && s1_r != SCORE_MAX) s1_r <= s1_r + 1'b1;
                  if (player_r == PLY_2 && s2_r != SCORE_MAX) s2_r <= s2_r + 1'b1;
               end else begin
                  if (player_r == PLY_1) lk1_r <= 1'b1;
                  if (player_r == PLY_2) lk2_r <= 1'b1;
               end
            end
            NEXT: begin
               timer_r <= '0;
               lk1_r   <= 1'b0;
               lk2_r   <= 1'b0;
               if (idx_r != LAST_IDX) idx_r <= idx_r + 8'd1;
            end
            default: begin
               timer_r <= timer_r;
            end
         endcase
      end
   end

   // Registered status outputs, aligned with the state they describe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         next_prob_r  <= 1'b0;
         round_done_r <= 1'b0;
         winner_r     <= WIN_NONE;
      end else begin
         next_prob_r  <= (state_s == NEXT);
         round_done_r <= (state_s == DONE);
         winner_r     <= (state_s == DONE) ? winner_s : WIN_NONE;
      end
   end

   assign prob_idx   = idx_r;
   assign next_prob  = next_prob_r;
   assign score_p1   = s1_r;
   assign score_p2   = s2_r;
   assign lock_p1    = lk1_r;
   assign lock_p2    = lk2_r;
   assign round_done = round_done_r;
   assign winner     = winner_r;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Scoreboard bench for quiz_round_ctrl: expected scores are queued per problem and
// checked whenever next_prob pulses; a second instance covers reset and saturation.
module tb_quiz_round_ctrl;

   localparam int D = 4;
   localparam int T = 60;

   logic       clk = 1'b0;
   logic       rst, start, start_sat;
   logic [7:0] rm;
   logic [3:0] ans;

   logic [7:0] prob_idx, sat_idx;
   logic       next_prob, sat_np;
   logic [3:0] score_p1, score_p2, sat_s1, sat_s2;
   logic       lock_p1, lock_p2, sat_l1, sat_l2;
   logic       round_done, sat_done;
   logic [1:0] winner, sat_win;

   typedef struct {
      logic [7:0] idx;
      logic [3:0] s1;
      logic [3:0] s2;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   n;

   always #5 clk = ~clk;

   quiz_round_ctrl #(.NUM_PROBLEMS(3), .ANS_TIMEOUT(T), .DEBOUNCE(D), .SCORE_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .rm_in_bcd(rm), .prob_ans(ans),
      .prob_idx(prob_idx), .next_prob(next_prob), .score_p1(score_p1), .score_p2(score_p2),
      .lock_p1(lock_p1), .lock_p2(lock_p2), .round_done(round_done), .winner(winner)
   );

   quiz_round_ctrl #(.NUM_PROBLEMS(20), .ANS_TIMEOUT(T), .DEBOUNCE(D), .SCORE_W(4)) dut_sat (
      .clk(clk), .rst(rst), .start(start_sat), .rm_in_bcd(rm), .prob_ans(ans),
      .prob_idx(sat_idx), .next_prob(sat_np), .score_p1(sat_s1), .score_p2(sat_s2),
      .lock_p1(sat_l1), .lock_p2(sat_l2), .round_done(sat_done), .winner(sat_win)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   task automatic cyc(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic press(input logic [7:0] v, input int hold);
      rm = v;
      cyc(hold);
      rm = 8'hFF;
      cyc(D + 3);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic pulse_start_sat();
      start_sat = 1'b1;
      cyc(1);
      start_sat = 1'b0;
   endtask

   task automatic expect_np(input logic [7:0] idx, input logic [3:0] s1, input logic [3:0] s2);
      exp_t e;
      e.idx = idx;
      e.s1  = s1;
      e.s2  = s2;
      exp_q.push_back(e);
   endtask

   // Monitor: every next_prob pulse must match the oldest queued expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && next_prob === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_next_prob: got pulse at idx %0d want none", prob_idx);
         end else begin
            e = exp_q.pop_front();
            check("np_idx", prob_idx, e.idx);
            check("np_score_p1", score_p1, e.s1);
            check("np_score_p2", score_p2, e.s2);
         end
      end
   end

   initial begin
      rst = 1'b1; start = 1'b0; start_sat = 1'b0; rm = 8'hFF; ans = 4'd0;
      cyc(3);
      check("reset_outputs",
            {prob_idx, next_prob, score_p1, score_p2, lock_p1, lock_p2, round_done, winner}, 32'd0);
      rst = 1'b0;
      cyc(D + 4);

      // Reset in the middle of a round with P1 at 3 points.
      ans = 4'd2;
      pulse_start_sat();
      repeat (3) press(8'b1011_1111, D + 3);
      check("sat_pre_reset_score", sat_s1, 32'd3);
      check("sat_pre_reset_idx", sat_idx, 32'd3);
      rst = 1'b1;
      #1;
      check("mid_round_reset_outputs",
            {sat_idx, sat_np, sat_s1, sat_s2, sat_l1, sat_l2, sat_done, sat_win}, 32'd0);
      cyc(2);
      rst = 1'b0;
      cyc(D + 4);
      pulse_start_sat();
      check("restart_idx_score", {sat_idx, sat_s1, sat_done}, 32'd0);

      // Score saturates at 15 after 16 correct answers.
      repeat (16) press(8'b1011_1111, D + 3);
      check("sat_score_15", sat_s1, 32'd15);
      check("sat_idx_16", sat_idx, 32'd16);

      // Round 1: glitch and two-key press ignored, then single and simultaneous presses.
      ans = 4'd2;
      pulse_start();
      press(8'b1011_1111, D - 1);
      press(8'b0011_1111, D + 3);
      check("glitch_and_multi_ignored", {score_p1, score_p2, lock_p1, prob_idx}, 32'd0);
      expect_np(8'd0, 4'd1, 4'd0);
      press(8'b1011_1111, D + 3);
      check("idx_after_first", prob_idx, 32'd1);
      ans = 4'd1;
      expect_np(8'd1, 4'd2, 4'd0);
      press(8'b0111_0111, D + 3);
      expect_np(8'd2, 4'd2, 4'd1);
      press(8'b0111_0111, D + 3);
      check("round1_done", round_done, 32'd1);
      check("round1_winner", winner, 32'd1);
      check("round1_idx_held", prob_idx, 32'd2);

      // Round 2: timeout on problem 0.
      expect_np(8'd0, 4'd0, 4'd0);
      pulse_start();
      n = 1;
      while (next_prob !== 1'b1 && n < T + 20) begin
         cyc(1);
         n++;
      end
      check("timeout_cycle", n, T + 1);
      check("not_done_winner", {round_done, winner}, 32'd0);

      // Problem 1: P1 wrong locks, P2 right scores and clears locks.
      ans = 4'd4;
      press(8'b0111_1111, D + 3);
      check("lock_p1_set", {lock_p1, lock_p2}, 32'd2);
      check("no_advance_on_wrong", prob_idx, 32'd1);
      expect_np(8'd1, 4'd0, 4'd1);
      press(8'b1111_1110, D + 3);
      check("locks_cleared", {lock_p1, lock_p2}, 32'd0);
      check("idx_after_lock_test", prob_idx, 32'd2);

      // Problem 2: locked P1's correct press is discarded; both wrong advances.
      ans = 4'd3;
      press(8'b0111_1111, D + 3);
      press(8'b1101_1111, D + 3);
      check("locked_press_discarded", {score_p1, lock_p1, prob_idx}, {23'd0, 1'b1, 8'd2});
      expect_np(8'd2, 4'd0, 4'd1);
      press(8'b1111_0111, D + 3);
      check("round2_done", round_done, 32'd1);
      check("round2_winner", winner, 32'd2);

      cyc(5);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
